key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_pkg.sv | 49 ++++
 rtl/key_evt_fifo.sv | 47 ++++
 rtl/key_event_ctrl.sv | 124 ++++++++++++
 tb/tb_key_event_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared PS/2 arrow-key definitions: scancodes, key code encoding, decoder states
// and the event record carried by the event FIFO.
package key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        KEY_UP    = 2'd0,
        KEY_DOWN  = 2'd1,
        KEY_LEFT  = 2'd2,
        KEY_RIGHT = 2'd3
    } key_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    typedef struct packed {
        key_code_e code;
        logic      press;
    } key_evt_t;

    function automatic logic sc_is_dir(input logic [7:0] sc);
        return (sc == SC_UP) || (sc == SC_DOWN) || (sc == SC_LEFT) || (sc == SC_RIGHT);
    endfunction

    function automatic key_code_e sc_to_key(input logic [7:0] sc);
        case (sc)
            SC_DOWN:  return KEY_DOWN;
            SC_LEFT:  return KEY_LEFT;
            SC_RIGHT: return KEY_RIGHT;
            default:  return KEY_UP;
        endcase
    endfunction

    // key_state is ordered {up,down,left,right}, so code k lives at bit 3-k.
    function automatic logic [3:0] key_mask(input key_code_e k);
        return 4'b1000 >> k;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small event FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module key_evt_fifo
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push_i,
    input  logic     pop_i,
    input  key_evt_t data_i,
    output key_evt_t data_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_q, rd_q;
    key_evt_t    mem_q [FIFO_DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 arrow-key controller: scancode decoder with prefix timeout, held-key map and event FIFO.
// Optional macro KEY_REPEAT_FILTER_EN drops typematic makes and unmatched breaks from the FIFO.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       evt_press,
    output logic [3:0] key_state,
    output logic       overflow
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       keys_q, keys_d;
    logic             ovf_q, ovf_d;

    logic      evt_fire, evt_make, push_evt;
    key_code_e evt_key;
    logic [3:0] evt_mask;
    logic      fifo_full, fifo_empty, fifo_pop;
    key_evt_t  push_data, head_data;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        evt_fire = 1'b0;
        evt_make = 1'b1;
        evt_key  = sc_to_key(rx_byte);
        if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                ST_IDLE, ST_EXT: begin
                    if (rx_byte == SC_BRK) begin
                        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
                    end else if (rx_byte == SC_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d  = ST_IDLE;
                        evt_fire = sc_is_dir(rx_byte);
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    evt_fire = sc_is_dir(rx_byte);
                    evt_make = 1'b0;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // An abandoned prefix must not turn the next direction byte into a break.
            if (cnt_q == TIMEOUT_LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign evt_mask = key_mask(evt_key);

`ifdef KEY_REPEAT_FILTER_EN
    assign push_evt = evt_fire & (evt_make ^ (|(keys_q & evt_mask)));
`else
    assign push_evt = evt_fire;
`endif

    always_comb begin
        keys_d = keys_q;
        if (evt_fire) begin
            keys_d = evt_make ? (keys_q | evt_mask) : (keys_q & ~evt_mask);
        end
        ovf_d = ovf_q | (push_evt & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            keys_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keys_q  <= keys_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_pop  = evt_ready & ~fifo_empty;
    assign push_data = '{code: evt_key, press: evt_make};

    key_evt_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push_evt),
        .pop_i  (fifo_pop),
        .data_i (push_data),
        .data_o (head_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = head_data.code;
    assign evt_press = head_data.press;
    assign key_state = keys_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: directed table, prefix timeout and reset
// sequences, then random traffic against a queue-based behavioural model.
module tb_key_event_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_press;
    logic [3:0] key_state;
    logic       overflow;

    key_event_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .evt_ready(evt_ready),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .evt_press(evt_press),
        .key_state(key_state),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: a queue of events, a held-key vector and two prefix flags.
    typedef struct packed {
        logic [1:0] code;
        logic       press;
    } evt_t;

    evt_t       mQ[$];
    logic [3:0] mKeys;
    logic       mOvf;
    bit         mExt;
    bit         mBrk;
    int         mIdle;

    function automatic int keyOf(input logic [7:0] b);
        case (b)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        mQ.delete();
        mKeys = 4'b0000;
        mOvf  = 1'b0;
        mExt  = 0;
        mBrk  = 0;
        mIdle = 0;
    endtask

    task automatic modelStep(input logic v, input logic [7:0] b, input logic r);
        int   k;
        int   sizeBefore;
        bit   popNow;
        bit   make;
        bit   held;
        bit   pushIt;
        evt_t e;
        sizeBefore = mQ.size();
        popNow     = r && (sizeBefore > 0);
        if (popNow) void'(mQ.pop_front());
        if (v) begin
            mIdle = 0;
            k     = keyOf(b);
            if (k >= 0) begin
                make   = !mBrk;
                held   = mKeys[3-k];
                mKeys[3-k] = make;
`ifdef KEY_REPEAT_FILTER_EN
                pushIt = (make != held);
`else
                pushIt = 1;
`endif
                if (pushIt) begin
                    if (sizeBefore < DEPTH || popNow) begin
                        e.code  = 2'(k);
                        e.press = make;
                        mQ.push_back(e);
                    end else begin
                        mOvf = 1'b1;
                    end
                end
                mExt = 0;
                mBrk = 0;
            end else if (!mBrk && b == 8'hE0) begin
                mExt = 1;
            end else if (!mBrk && b == 8'hF0) begin
                mBrk = 1;
            end else begin
                mExt = 0;
                mBrk = 0;
            end
        end else if (mExt || mBrk) begin
            mIdle++;
            if (mIdle == TIMEOUT) begin
                mExt  = 0;
                mBrk  = 0;
                mIdle = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input bit strict, input logic eV,
                               input logic [1:0] eC, input logic eP,
                               input logic [3:0] eK, input logic eO);
        bit bad;
        vecCount++;
        bad = (evt_valid !== eV) || (key_state !== eK) || (overflow !== eO);
        if (eV || strict) bad = bad || (evt_code !== eC) || (evt_press !== eP);
        if (bad) begin
            missCount++;
            $display("[TB] FAIL %s: got valid=%0b code=%0d press=%0b keys=%b ovf=%0b, expected valid=%0b code=%0d press=%0b keys=%b ovf=%0b",
                     tag, evt_valid, evt_code, evt_press, key_state, overflow, eV, eC, eP, eK, eO);
        end
    endtask

    task automatic checkModel(input string tag);
        logic       eV;
        logic [1:0] eC;
        logic       eP;
        eV = (mQ.size() > 0);
        eC = eV ? mQ[0].code : 2'd0;
        eP = eV ? mQ[0].press : 1'b0;
        checkOutput(tag, 1'b0, eV, eC, eP, mKeys, mOvf);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare after it.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic r, input string tag);
        rx_valid  = v;
        rx_byte   = b;
        evt_ready = r;
        @(posedge clk);
        modelStep(v, b, r);
        #1;
        checkModel(tag);
    endtask

    task automatic doReset(input bit checkAsync);
        rx_valid  = 1'b0;
        evt_ready = 1'b0;
        reset     = 1'b0;
        modelReset();
        if (checkAsync) begin
            #1;
            checkOutput("reset_async", 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] b;
        logic       r;
        logic       eValid;
        logic [1:0] eCode;
        logic       ePress;
        logic [3:0] eKeys;
        logic       eOvf;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input logic v, input logic [7:0] b, input logic r, input logic eV,
                          input logic [1:0] eC, input logic eP, input logic [3:0] eK, input logic eO);
        vec_t t;
        t.v = v; t.b = b; t.r = r;
        t.eValid = eV; t.eCode = eC; t.ePress = eP; t.eKeys = eK; t.eOvf = eO;
        tbl.push_back(t);
    endtask

    logic [7:0] pool [8];
    int         seen;

    initial begin
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1C, 8'h00};
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        evt_ready = 1'b0;
        reset     = 1'b0;
        doReset(0);

        // Extended make up, then extended break up, then six alternating makes into a full FIFO.
        addVec(1, 8'hE0, 1, 0, 2'd0, 0, 4'b0000, 0);
        addVec(1, 8'h75, 1, 1, 2'd0, 1, 4'b1000, 0);
        addVec(0, 8'h00, 1, 0, 2'd0, 0, 4'b1000, 0);
        addVec(1, 8'hE0, 0, 0, 2'd0, 0, 4'b1000, 0);
        addVec(1, 8'hF0, 0, 0, 2'd0, 0, 4'b1000, 0);
        addVec(1, 8'h75, 0, 1, 2'd0, 0, 4'b0000, 0);
        addVec(0, 8'h00, 1, 0, 2'd0, 0, 4'b0000, 0);
        addVec(1, 8'h6B, 0, 1, 2'd2, 1, 4'b0010, 0);
        addVec(1, 8'h74, 0, 1, 2'd2, 1, 4'b0011, 0);
        addVec(1, 8'h6B, 0, 1, 2'd2, 1, 4'b0011, 0);
        addVec(1, 8'h74, 0, 1, 2'd2, 1, 4'b0011, 0);
`ifdef KEY_REPEAT_FILTER_EN
        addVec(1, 8'h6B, 0, 1, 2'd2, 1, 4'b0011, 0);
        addVec(1, 8'h74, 0, 1, 2'd2, 1, 4'b0011, 0);
        addVec(0, 8'h00, 1, 1, 2'd3, 1, 4'b0011, 0);
        addVec(0, 8'h00, 1, 0, 2'd0, 0, 4'b0011, 0);
        addVec(0, 8'h00, 1, 0, 2'd0, 0, 4'b0011, 0);
        addVec(0, 8'h00, 1, 0, 2'd0, 0, 4'b0011, 0);
`else
        addVec(1, 8'h6B, 0, 1, 2'd2, 1, 4'b0011, 1);
        addVec(1, 8'h74, 0, 1, 2'd2, 1, 4'b0011, 1);
        addVec(0, 8'h00, 1, 1, 2'd3, 1, 4'b0011, 1);
        addVec(0, 8'h00, 1, 1, 2'd2, 1, 4'b0011, 1);
        addVec(0, 8'h00, 1, 1, 2'd3, 1, 4'b0011, 1);
        addVec(0, 8'h00, 1, 0, 2'd0, 0, 4'b0011, 1);
`endif

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, tbl[i].b, tbl[i].r, $sformatf("table_model[%0d]", i));
            checkOutput($sformatf("table[%0d]", i), 1'b0, tbl[i].eValid, tbl[i].eCode,
                        tbl[i].ePress, tbl[i].eKeys, tbl[i].eOvf);
        end

        // Prefix timeout: E0 + timeout still makes; F0 one cycle short breaks; F0 + timeout makes.
        doReset(1);
        applyStimulus(1, 8'hE0, 1, "to_e0");
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(0, 8'h00, 1, "to_idle_a");
        applyStimulus(1, 8'h72, 1, "to_make_a");
        checkOutput("timeout_ext_make", 1'b0, 1, 2'd1, 1, 4'b0100, 0);
        applyStimulus(1, 8'hF0, 1, "to_f0_b");
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 8'h00, 1, "to_idle_b");
        applyStimulus(1, 8'h72, 1, "to_break_b");
        checkOutput("timeout_edge_break", 1'b0, 1, 2'd1, 0, 4'b0000, 0);
        applyStimulus(1, 8'hF0, 1, "to_f0_c");
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(0, 8'h00, 1, "to_idle_c");
        applyStimulus(1, 8'h72, 1, "to_make_c");
        checkOutput("timeout_brk_make", 1'b0, 1, 2'd1, 1, 4'b0100, 0);

        // Repeated make of the same key: filter keeps one event, otherwise all three.
        doReset(1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h75, 0, "rep_make");
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (evt_valid === 1'b1) seen++;
            applyStimulus(0, 8'h00, 1, "rep_drain");
        end
        vecCount++;
`ifdef KEY_REPEAT_FILTER_EN
        if (seen != 1) begin
            missCount++;
            $display("[TB] FAIL repeat_count: got %0d events, expected 1", seen);
        end
`else
        if (seen != 3) begin
            missCount++;
            $display("[TB] FAIL repeat_count: got %0d events, expected 3", seen);
        end
`endif

        // Reset in the middle of a break prefix discards it.
        doReset(1);
        applyStimulus(1, 8'h75, 0, "mid_make");
        applyStimulus(1, 8'hF0, 0, "mid_f0");
        doReset(1);
        applyStimulus(1, 8'h75, 0, "post_reset");
        checkOutput("post_reset_make", 1'b0, 1, 2'd0, 1, 4'b1000, 0);

        // Random traffic with occasional idle runs around the timeout and rare resets.
        doReset(1);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                int gap;
                gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                for (int g = 0; g < gap; g++)
                    applyStimulus(0, 8'h00, 1'($urandom_range(0, 1)), "rand_gap");
            end
            if ($urandom_range(0, 499) == 0) doReset(1);
            applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                          1'($urandom_range(0, 3) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
